regbank_wb_arbiter: RTL and testbench
=====================================

REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-003 SHALL have ports: req_valid[2:0]  input  3  per-requester write request (0 = memory load, 1 = ALU writeback, 2 = debug/loader).
REQ-004 SHALL have ports: req_addr0/1/2  input  4 each  destination register.
REQ-005 SHALL have ports: req_data0/1/2  input  32 each  write data; in high-half mode only bits 15:0 are used.
REQ-006 SHALL have ports: req_high[2:0]  input  3  1 = write upper 16 bits only, 0 = full 32-bit write.
REQ-007 SHALL have ports: req_lock[2:0]  input  3  1 = keep grant for the next beat of this requester (see Configuration).
REQ-008 SHALL have ports: req_ready[2:0]  output  3  combinational grant; a beat is accepted when valid and ready are both 1 in the same cycle.
REQ-009 SHALL have ports: addr_d  output  4, data_d  output  32, we  output  1, we_high  output  1  registered register-bank write port.
REQ-010 SHALL have port: drop_cnt  output  8  saturating count of accepted writes that targeted r0.

Function
REQ-011 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid=1.
REQ-012 SHALL grant round-robin: priority order starts at the requester after the last accepted one and wraps 2->0.
REQ-013 SHALL register an accepted beat onto addr_d/data_d/we_high and assert we exactly one cycle after acceptance (latency 1).
REQ-014 SHALL drive we=0 in any cycle following a cycle with no accepted beat; addr_d/data_d/we_high hold their previous values.
REQ-015 SHALL accept a beat with addr=0 (ready=1), drive we=0 for it, and increment drop_cnt, saturating at 255.
REQ-016 SHALL pass data_d unmodified for both modes; we_high mirrors the accepted req_high bit.
REQ-017 SHALL sustain one accepted beat per cycle when any requester is valid (no bubble cycles).
REQ-018 SHALL leave the pointer unchanged in idle cycles (all req_valid=0).
REQ-019 SHALL not depend on req_addr/req_data/req_high/req_lock of non-valid requesters.

Reset
REQ-020 SHALL, while reset=0 at a clock edge, clear we, we_high, addr_d, data_d, drop_cnt, lock state and lock counter, and set the pointer so priority is 0>1>2.
REQ-021 SHALL drive req_ready=0 in every cycle in which reset=0.
REQ-022 SHALL discard a beat presented in a reset cycle; we=0 in the cycle after reset deasserts.

Configuration
REQ-023 SHALL compile the lock feature only when macro REGBANK_ARB_LOCK_EN is defined.
REQ-024 SHALL, with REGBANK_ARB_LOCK_EN: after an accepted beat with req_lock=1, grant only that requester (others' ready=0) until it has a beat accepted with req_lock=0.
REQ-025 SHALL, with REGBANK_ARB_LOCK_EN: while locked, an idle cycle of the owner keeps the lock; no other requester is granted.
REQ-026 SHALL, with REGBANK_ARB_LOCK_EN: force-release the lock after 4 consecutive locked beats (the 4th beat's lock bit is ignored), with round-robin resuming after the owner.
REQ-027 SHALL, without REGBANK_ARB_LOCK_EN: ignore req_lock entirely; pure round-robin.

Verification
REQ-028 SHALL cover: after reset, req_valid=3'b111 for 6 cycles -> grants 0,1,2,0,1,2; we=1 each cycle from cycle 2.
REQ-029 SHALL cover: requester 1 writes addr=5, data=32'hDEADBEEF, high=0 -> next cycle addr_d=5, data_d=32'hDEADBEEF, we=1, we_high=0.
REQ-030 SHALL cover: requester 2 writes addr=0 three times -> we stays 0; drop_cnt=3; 300 such writes -> drop_cnt=255.
REQ-031 SHALL cover: with REGBANK_ARB_LOCK_EN, req 0 lock=1 with all valid -> grants 0,0,0,0 then 1; req 1 and 2 ready=0 during lock.
REQ-032 SHALL cover: reset=0 asserted in the same cycle as an accepted request -> we=0 next cycle, req_ready=0, drop_cnt=0, next grant to requester 0.
REQ-033 SHALL cover: requester 0 high write addr=3, data=32'h0000ABCD, high=1 -> we=1, we_high=1, data_d=32'h0000ABCD.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wb_arbiter
//
// Purpose:
//   Arbitrates three write-back sources (memory load, ALU writeback and the
//   debug/loader port) onto the single write port of a 16-entry register
//   bank. Grants are round-robin, at most one requester is accepted per
//   cycle, and the accepted beat appears on the registered write port one
//   cycle later. Writes that target r0 are accepted but never reach the
//   bank; they are counted in a saturating 8-bit drop counter.
//
// Optional feature (macro REGBANK_ARB_LOCK_EN):
//   When REGBANK_ARB_LOCK_EN is defined, a requester that has a beat
//   accepted with req_lock=1 keeps exclusive ownership of the grant until
//   it has a beat accepted with req_lock=0, or until four consecutive
//   locked beats have gone through (the fourth beat always releases).
//   Without the macro req_lock is ignored and arbitration is pure
//   round-robin.
//
// Ports:
//   clk                  in   1   single clock, rising edge
//   reset                in   1   synchronous, active-low (0 = reset)
//   req_valid[2:0]       in   3   per-requester write request
//   req_addr0/1/2        in   4   destination register per requester
//   req_data0/1/2        in  32   write data per requester
//   req_high[2:0]        in   3   1 = upper-half write, 0 = full write
//   req_lock[2:0]        in   3   1 = keep grant for the next beat
//   req_ready[2:0]       out  3   combinational one-hot grant
//   addr_d               out  4   registered write address
//   data_d               out 32   registered write data
//   we                   out  1   registered write enable
//   we_high              out  1   registered upper-half write flag
//   drop_cnt             out  8   saturating count of accepted r0 writes
// ---------------------------------------------------------------------------
module regbank_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [3:0]  req_addr0,
  input  logic [3:0]  req_addr1,
  input  logic [3:0]  req_addr2,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  input  logic [2:0]  req_high,
  input  logic [2:0]  req_lock,
  output logic [2:0]  req_ready,
  output logic [3:0]  addr_d,
  output logic [31:0] data_d,
  output logic        we,
  output logic        we_high,
  output logic [7:0]  drop_cnt
);

  // Index of the most recently accepted requester. Round-robin priority
  // starts at the requester after this one, so resetting it to 2 gives the
  // power-up priority order 0 > 1 > 2.
  logic [1:0]  last_grant;

  // Round-robin winner, ignoring any lock ownership.
  logic [1:0]  rr_idx;
  logic        rr_any;
  logic [1:0]  rr_cand;

  // Final grant after lock ownership has been applied.
  logic [1:0]  grant_idx;
  logic        grant_any;
  logic        accept;

  // Fields of the granted requester.
  logic [3:0]  sel_addr;
  logic [31:0] sel_data;
  logic        sel_high;

  // Advance a requester index with wrap 2 -> 0.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin search: walk the three requesters starting after the last
  // accepted one and pick the first that is valid.
  always_comb begin
    rr_idx  = 2'd0;
    rr_any  = 1'b0;
    rr_cand = wrap_inc(last_grant);
    for (int k = 0; k < 3; k++) begin
      if (!rr_any && req_valid[rr_cand]) begin
        rr_idx = rr_cand;
        rr_any = 1'b1;
      end
      rr_cand = wrap_inc(rr_cand);
    end
  end

`ifdef REGBANK_ARB_LOCK_EN

  // Lock ownership. LOCK_HELD means lock_owner is the only requester that
  // may be granted; lock_beats counts locked beats already accepted in the
  // current ownership so the fourth one can force a release.
  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_t;

  lock_state_t lock_state;
  logic [1:0]  lock_owner;
  logic [1:0]  lock_beats;
  logic        sel_lock;

  // While locked the owner is the only candidate; an idle owner simply
  // leaves the grant empty rather than handing it to someone else.
  always_comb begin
    grant_idx = rr_idx;
    grant_any = rr_any;
    if (lock_state == LOCK_HELD) begin
      grant_idx = lock_owner;
      grant_any = req_valid[lock_owner];
    end
  end

  // Lock bit of the granted requester.
  always_comb begin
    case (grant_idx)
      2'd0:    sel_lock = req_lock[0];
      2'd1:    sel_lock = req_lock[1];
      default: sel_lock = req_lock[2];
    endcase
  end

  // Lock state machine. It only moves on accepted beats. Entering LOCK_HELD
  // counts the entering beat as the first locked beat; the beat that would
  // be the fourth releases regardless of its own lock bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_state <= LOCK_IDLE;
      lock_owner <= 2'd0;
      lock_beats <= 2'd0;
    end else if (accept) begin
      case (lock_state)
        LOCK_IDLE: begin
          if (sel_lock) begin
            lock_state <= LOCK_HELD;
            lock_owner <= grant_idx;
            lock_beats <= 2'd1;
          end
        end
        LOCK_HELD: begin
          if (!sel_lock || lock_beats == 2'd3) begin
            lock_state <= LOCK_IDLE;
            lock_beats <= 2'd0;
          end else begin
            lock_beats <= lock_beats + 2'd1;
          end
        end
        default: begin
          lock_state <= LOCK_IDLE;
          lock_beats <= 2'd0;
        end
      endcase
    end
  end

`else

  // No lock support: the round-robin winner is the grant and the lock
  // inputs are deliberately left unconnected to any logic.
  logic unused_lock;

  assign grant_idx   = rr_idx;
  assign grant_any   = rr_any;
  assign unused_lock = ^req_lock;

`endif

  // A beat is accepted whenever some requester is granted outside reset.
  // The grant only ever points at a valid requester, so valid & ready is
  // implied by accept.
  assign accept = reset && grant_any;

  // One-hot ready. Held at zero throughout reset so nothing is accepted
  // in a reset cycle.
  always_comb begin
    req_ready = 3'b000;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Steer the granted requester's fields onto the write path. Only the
  // granted requester is looked at, so non-valid requesters cannot
  // influence anything.
  always_comb begin
    case (grant_idx)
      2'd0: begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        sel_high = req_high[0];
      end
      2'd1: begin
        sel_addr = req_addr1;
        sel_data = req_data1;
        sel_high = req_high[1];
      end
      default: begin
        sel_addr = req_addr2;
        sel_data = req_data2;
        sel_high = req_high[2];
      end
    endcase
  end

  // Registered write port, pointer and drop counter. we pulses for exactly
  // one cycle per accepted non-r0 beat; the address/data/high registers
  // hold their last written values otherwise. An r0 beat is consumed (the
  // pointer moves past it) but only bumps the saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we         <= 1'b0;
      we_high    <= 1'b0;
      addr_d     <= 4'd0;
      data_d     <= 32'd0;
      drop_cnt   <= 8'd0;
      last_grant <= 2'd2;
    end else begin
      we <= 1'b0;
      if (accept) begin
        last_grant <= grant_idx;
        if (sel_addr == 4'd0) begin
          if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end else begin
          we      <= 1'b1;
          addr_d  <= sel_addr;
          data_d  <= sel_data;
          we_high <= sel_high;
        end
      end
    end
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_wb_arbiter
//
// Purpose:
//   Self-checking bench for regbank_wb_arbiter. Directed scenarios cover
//   reset, round-robin order, single full/high writes, r0 drops with
//   saturation, reset during traffic, idle pointer hold and the lock
//   feature (when REGBANK_ARB_LOCK_EN is defined). A randomized run is
//   checked cycle by cycle against a behavioural model of the arbiter.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [3:0]  ra [3];
  logic [31:0] rd [3];
  logic [2:0]  req_high;
  logic [2:0]  req_lock;
  logic [2:0]  req_ready;
  logic [3:0]  addr_d;
  logic [31:0] data_d;
  logic        we;
  logic        we_high;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: who was accepted last, expected write port
  // contents, drop count and lock ownership.
  int          m_last;
  int          m_drop;
  bit          m_we;
  bit          m_high;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  bit          m_locked;
  int          m_owner;
  int          m_beats;

  regbank_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr0 (ra[0]),
    .req_addr1 (ra[1]),
    .req_addr2 (ra[2]),
    .req_data0 (rd[0]),
    .req_data1 (rd[1]),
    .req_data2 (rd[2]),
    .req_high  (req_high),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .addr_d    (addr_d),
    .data_d    (data_d),
    .we        (we),
    .we_high   (we_high),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Expected grant from the arbitration rules: nothing in reset, only the
  // owner while locked, otherwise the first valid requester after the
  // last accepted one.
  function automatic int model_grant();
    if (!reset) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int g);
    logic [2:0] v;
    v = 3'b000;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Drive one requester's fields.
  task automatic applyStimulus(input int i, input logic v, input logic [3:0] a,
                               input logic [31:0] d, input logic h, input logic l);
    req_valid[i] = v;
    ra[i]        = a;
    rd[i]        = d;
    req_high[i]  = h;
    req_lock[i]  = l;
  endtask

  // One clock: sample ready mid-cycle, compute the expected grant, then
  // apply the rules to the model at the rising edge. Returns 1 ns after
  // the edge, which is where registered outputs are sampled and the next
  // inputs are driven.
  task automatic advance(output int g, output logic [2:0] rdy);
    @(negedge clk);
    rdy = req_ready;
    g   = model_grant();
    @(posedge clk);
    if (!reset) begin
      m_we = 0; m_high = 0; m_addr = '0; m_data = '0; m_drop = 0;
      m_last = 2; m_locked = 0; m_owner = 0; m_beats = 0;
    end else begin
      m_we = 0;
      if (g >= 0) begin
        m_last = g;
        if (ra[g] == 4'd0) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_we   = 1;
          m_addr = ra[g];
          m_data = rd[g];
          m_high = req_high[g];
        end
`ifdef REGBANK_ARB_LOCK_EN
        if (m_locked) begin
          m_beats++;
          if (!req_lock[g] || m_beats == 4) begin
            m_locked = 0;
            m_beats  = 0;
          end
        end else if (req_lock[g]) begin
          m_locked = 1;
          m_owner  = g;
          m_beats  = 1;
        end
`endif
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    int g;
    logic [2:0] r;
    reset = 1'b0;
    clear_inputs();
    advance(g, r);
    advance(g, r);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int g;
    logic [2:0] r;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'(i + 1), $urandom, 1'b1, 1'b0);
    advance(g, r);
    checks++; if (r !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", r); end
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", we); end
    checks++; if (we_high !== 1'b0) begin errors++; $display("[TB] FAIL reset_we_high: got %b expected 0", we_high); end
    checks++; if (addr_d !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr_d: got %0h expected 0", addr_d); end
    checks++; if (data_d !== 32'd0) begin errors++; $display("[TB] FAIL reset_data_d: got %0h expected 0", data_d); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_round_robin();
    int g;
    logic [2:0] r;
    int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'(i + 1), $urandom, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      advance(g, r);
      checks++; if (r !== onehot(exp_seq[c])) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", c, r, onehot(exp_seq[c])); end
      checks++; if (we !== 1'b1) begin errors++; $display("[TB] FAIL rr_we[%0d]: got %b expected 1", c, we); end
      checks++; if (addr_d !== 4'(exp_seq[c] + 1)) begin errors++; $display("[TB] FAIL rr_addr_d[%0d]: got %0d expected %0d", c, addr_d, exp_seq[c] + 1); end
    end
  endtask

  task automatic test_full_write();
    int g;
    logic [2:0] r;
    do_reset();
    applyStimulus(1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 4'd9, 32'h11111111, 1'b1, 1'b1);
    advance(g, r);
    checks++; if (r !== 3'b010) begin errors++; $display("[TB] FAIL full_ready: got %b expected 010", r); end
    checks++; if (we !== 1'b1) begin errors++; $display("[TB] FAIL full_we: got %b expected 1", we); end
    checks++; if (addr_d !== 4'd5) begin errors++; $display("[TB] FAIL full_addr_d: got %0d expected 5", addr_d); end
    checks++; if (data_d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL full_data_d: got %h expected deadbeef", data_d); end
    checks++; if (we_high !== 1'b0) begin errors++; $display("[TB] FAIL full_we_high: got %b expected 0", we_high); end
    clear_inputs();
    advance(g, r);
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL idle_we: got %b expected 0", we); end
    checks++; if (addr_d !== 4'd5 || data_d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL idle_hold: got %0d/%h expected 5/deadbeef", addr_d, data_d); end
  endtask

  task automatic test_high_write();
    int g;
    logic [2:0] r;
    do_reset();
    applyStimulus(0, 1'b1, 4'd3, 32'h0000ABCD, 1'b1, 1'b0);
    advance(g, r);
    checks++; if (r !== 3'b001) begin errors++; $display("[TB] FAIL high_ready: got %b expected 001", r); end
    checks++; if (we !== 1'b1 || we_high !== 1'b1) begin errors++; $display("[TB] FAIL high_we: got we=%b we_high=%b expected 1/1", we, we_high); end
    checks++; if (data_d !== 32'h0000ABCD || addr_d !== 4'd3) begin errors++; $display("[TB] FAIL high_data: got %0d/%h expected 3/0000abcd", addr_d, data_d); end
  endtask

  task automatic test_drop();
    int g;
    logic [2:0] r;
    do_reset();
    applyStimulus(2, 1'b1, 4'd0, 32'hCAFE0000, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      advance(g, r);
      checks++; if (r !== 3'b100) begin errors++; $display("[TB] FAIL drop_ready[%0d]: got %b expected 100", c, r); end
      checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL drop_we[%0d]: got %b expected 0", c, we); end
    end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("[TB] FAIL drop_cnt3: got %0d expected 3", drop_cnt); end
    for (int c = 0; c < 297; c++) advance(g, r);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL drop_sat: got %0d expected 255", drop_cnt); end
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL drop_sat_we: got %b expected 0", we); end
  endtask

  task automatic test_reset_mid();
    int g;
    logic [2:0] r;
    do_reset();
    applyStimulus(0, 1'b1, 4'd0, 32'h1, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 4'd6, 32'h2, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 4'd8, 32'h3, 1'b0, 1'b0);
    advance(g, r);
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_pre_drop: got %0d expected 1", drop_cnt); end
    ra[0] = 4'd7;
    reset = 1'b0;
    advance(g, r);
    checks++; if (r !== 3'b000) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 000", r); end
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL mid_we: got %b expected 0", we); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_drop: got %0d expected 0", drop_cnt); end
    reset = 1'b1;
    advance(g, r);
    checks++; if (r !== 3'b001) begin errors++; $display("[TB] FAIL mid_next_grant: got %b expected 001", r); end
    checks++; if (we !== 1'b1 || addr_d !== 4'd7) begin errors++; $display("[TB] FAIL mid_next_write: got we=%b addr=%0d expected 1/7", we, addr_d); end
  endtask

  task automatic test_idle_pointer();
    int g;
    logic [2:0] r;
    do_reset();
    applyStimulus(0, 1'b1, 4'd1, 32'h10, 1'b0, 1'b0);
    advance(g, r);
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      advance(g, r);
      checks++; if (r !== 3'b000 || we !== 1'b0) begin errors++; $display("[TB] FAIL idle_quiet[%0d]: got ready=%b we=%b expected 000/0", c, r, we); end
    end
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'(i + 4), $urandom, 1'b0, 1'b0);
    advance(g, r);
    checks++; if (r !== 3'b010) begin errors++; $display("[TB] FAIL idle_resume: got %b expected 010", r); end
  endtask

`ifdef REGBANK_ARB_LOCK_EN
  task automatic test_lock();
    int g;
    logic [2:0] r;
    logic [2:0] exp_seq[5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'(i + 1), $urandom, 1'b0, i == 0);
    for (int c = 0; c < 5; c++) begin
      advance(g, r);
      checks++; if (r !== exp_seq[c]) begin errors++; $display("[TB] FAIL lock_seq[%0d]: got %b expected %b", c, r, exp_seq[c]); end
    end
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'(i + 1), $urandom, 1'b0, i == 0);
    advance(g, r);
    req_valid[0] = 1'b0;
    advance(g, r);
    checks++; if (r !== 3'b000) begin errors++; $display("[TB] FAIL lock_idle_owner: got %b expected 000", r); end
    req_valid[0] = 1'b1;
    req_lock[0]  = 1'b0;
    advance(g, r);
    checks++; if (r !== 3'b001) begin errors++; $display("[TB] FAIL lock_release_beat: got %b expected 001", r); end
    advance(g, r);
    checks++; if (r !== 3'b010) begin errors++; $display("[TB] FAIL lock_after_release: got %b expected 010", r); end
  endtask
`else
  task automatic test_lock_ignored();
    int g;
    logic [2:0] r;
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'(i + 1), $urandom, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      advance(g, r);
      checks++; if (r !== onehot(c)) begin errors++; $display("[TB] FAIL nolock_rr[%0d]: got %b expected %b", c, r, onehot(c)); end
    end
  endtask
`endif

  task automatic test_random();
    int g;
    logic [2:0] r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < 3; i++)
        applyStimulus(i, 1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
                      $urandom, 1'($urandom), 1'($urandom));
      advance(g, r);
      checks++; if (r !== onehot(g)) begin errors++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, r, onehot(g)); end
      checks++; if (we !== m_we) begin errors++; $display("[TB] FAIL rand_we[%0d]: got %b expected %b", c, we, m_we); end
      checks++; if (drop_cnt !== m_drop[7:0]) begin errors++; $display("[TB] FAIL rand_drop[%0d]: got %0d expected %0d", c, drop_cnt, m_drop); end
      if (m_we) begin
        checks++;
        if (addr_d !== m_addr || data_d !== m_data || we_high !== m_high) begin
          errors++;
          $display("[TB] FAIL rand_write[%0d]: got %0d/%h/%b expected %0d/%h/%b", c, addr_d, data_d, we_high, m_addr, m_data, m_high);
        end
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    m_last = 2; m_drop = 0; m_we = 0; m_high = 0; m_addr = '0; m_data = '0;
    m_locked = 0; m_owner = 0; m_beats = 0;
    test_reset();
    test_round_robin();
    test_full_write();
    test_high_write();
    test_drop();
    test_reset_mid();
    test_idle_pointer();
`ifdef REGBANK_ARB_LOCK_EN
    test_lock();
`else
    test_lock_ignored();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
